// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_pkg
// Description : Shared constants for the counter run controller: FSM state
//               encodings and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

    // Default width of the counter, limit and pass counter
    localparam int DEFAULT_WIDTH = 4;

    // FSM state encodings, visible to the host on the state output
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

endpackage : counter_ctrl_pkg
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
// Module      : counter_core
// Description : Plain WIDTH-bit up-counter with synchronous reset, a clear
//               strobe and a count enable. Clear takes priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;

    // Counter register: reset/clear to zero, otherwise step when enabled
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_q <= '0;
        end else if (enable) begin
            r_q <= r_q + C_ONE;
        end
    end

    assign q = r_q;

endmodule : counter_core
`default_nettype wire

// File: rtl/counter_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : counter_run_controller
// Description : Runs the embedded up-counter through limit+1 counts per pass,
//               with start/pause/abort control, one-shot or auto-repeat
//               operation, a one-cycle done pulse and a completed-pass count.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_run_controller
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             repeat_mode,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pass_cnt,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_limit_q;
    logic             r_mode_q;
    logic [WIDTH-1:0] r_pass_cnt;
    logic             r_done;
    logic [WIDTH-1:0] w_count;

    // Control strobes decoded from the current state and inputs
    logic w_load;      // start accepted: latch limit/mode, restart the run
    logic w_clear;     // zero the counter (start, abort, repeat wrap)
    logic w_enable;    // plain increment
    logic w_terminal;  // terminal count reached in an active RUN cycle

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; abort outranks pause, pause outranks the terminal count
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (pause) begin
                    w_next_state = ST_PAUSE;
                end else if (w_count == r_limit_q) begin
                    w_next_state = r_mode_q ? ST_RUN : ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (!pause) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output/strobe decode driving the counter datapath and bookkeeping registers
    always_comb begin
        w_load     = 1'b0;
        w_clear    = 1'b0;
        w_enable   = 1'b0;
        w_terminal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load  = start;
                w_clear = start;
            end
            ST_RUN: begin
                if (abort) begin
                    w_clear = 1'b1;
                end else if (!pause) begin
                    if (w_count == r_limit_q) begin
                        w_terminal = 1'b1;
                        // Repeat mode wraps to zero; one-shot holds at the limit
                        w_clear    = r_mode_q;
                    end else begin
                        w_enable = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                w_clear = abort;
            end
            ST_DONE: begin
                if (abort) begin
                    w_clear = 1'b1;
                end else if (start) begin
                    w_load  = 1'b1;
                    w_clear = 1'b1;
                end
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    // Run configuration, latched only when a start is accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            r_limit_q <= '0;
            r_mode_q  <= 1'b0;
        end else if (w_load) begin
            r_limit_q <= limit;
            r_mode_q  <= repeat_mode;
        end
    end

    // Completed-pass counter; wraps silently and restarts on each accepted start
    always_ff @(posedge clock) begin
        if (reset || w_load) begin
            r_pass_cnt <= '0;
        end else if (w_terminal) begin
            r_pass_cnt <= r_pass_cnt + C_ONE;
        end
    end

    // Done pulse, registered one cycle after the terminal count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_terminal;
        end
    end

    counter_core #(
        .WIDTH (WIDTH)
    ) u_counter_core (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_enable),
        .q      (w_count)
    );

    assign count    = w_count;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done     = r_done;
    assign pass_cnt = r_pass_cnt;
    assign state    = r_state;

endmodule : counter_run_controller
`default_nettype wire
